// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared constants, register map and FSM encoding for irq_ctrl
package irq_ctrl_pkg;

    localparam logic [3:0]  IRQ_SLOT      = 4'h6;
    localparam logic [15:0] IRQ_BASE_ADDR = 16'hFF60;

    localparam logic [3:0] REG_CTRL      = 4'd0;
    localparam logic [3:0] REG_ENABLE    = 4'd1;
    localparam logic [3:0] REG_PENDING   = 4'd2;
    localparam logic [3:0] REG_INSERVICE = 4'd3;
    localparam logic [3:0] REG_SWTRIG    = 4'd4;
    localparam logic [3:0] REG_STATUS    = 4'd5;

    localparam int IRQ_UART  = 0;
    localparam int IRQ_TIMER = 1;

    // Source ids are at most 4 bits wide since IRQ_NUM is capped at 16.
    localparam int ID_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-first priority encoder (index 0 wins)
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]    bits,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    always_comb begin
        valid = |bits;
        id    = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (bits[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - vectored interrupt controller with ack/EOI handshake
// Optional nested preemption in SERVICE is enabled by defining IRQ_NESTED_EN.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int                   CPU_WIDTH  = 16,
    parameter int                   IRQ_NUM    = 8,
    parameter logic [CPU_WIDTH-1:0] VEC_BASE   = 16'h0010,
    parameter int                   VEC_STRIDE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IRQ_NUM-1:0]   irq_src,
    input  logic                 en,
    input  logic                 we,
    input  logic [3:0]           addr,
    input  logic [CPU_WIDTH-1:0] wdata,
    output logic [CPU_WIDTH-1:0] rdata,
    output logic                 irq_req,
    output logic [CPU_WIDTH-1:0] irq_vec,
    input  logic                 irq_ack,
    input  logic                 irq_eoi
);

    localparam int STRIDE_SH = $clog2(VEC_STRIDE);

    logic                 gie;
    logic [IRQ_NUM-1:0]   enable;
    logic [IRQ_NUM-1:0]   pending;
    logic [IRQ_NUM-1:0]   inservice;
    logic [IRQ_NUM-1:0]   irq_d;
    logic [ID_W-1:0]      cur_id;
    state_t               state;
    state_t               state_next;
    logic                 latch;

    logic [IRQ_NUM-1:0]   cand;
    logic                 cand_valid;
    logic [ID_W-1:0]      cand_id;
    logic                 is_valid;
    logic [ID_W-1:0]      is_id;
    logic [IRQ_NUM-1:0]   cur_mask;
    logic [IRQ_NUM-1:0]   is_mask;

    logic                 wr;
    logic [IRQ_NUM-1:0]   set_bits;
    logic [IRQ_NUM-1:0]   w1c_bits;
    logic                 withdraw;
    logic                 take_ack;
    logic                 take_eoi;
    logic [IRQ_NUM-1:0]   ack_clr;
    logic [IRQ_NUM-1:0]   eoi_clr;
    logic [IRQ_NUM-1:0]   pending_next;
    logic [IRQ_NUM-1:0]   inservice_next;
    logic [CPU_WIDTH-1:0] vec_calc;
    logic [CPU_WIDTH-1:0] rd_val;
    logic                 unused_wdata;

    assign unused_wdata = ^wdata;

    assign cand = gie ? (pending & enable) : '0;

    irq_prio_enc #(.N(IRQ_NUM)) u_cand_enc (
        .bits  (cand),
        .valid (cand_valid),
        .id    (cand_id)
    );

    irq_prio_enc #(.N(IRQ_NUM)) u_isr_enc (
        .bits  (inservice),
        .valid (is_valid),
        .id    (is_id)
    );

    assign cur_mask = IRQ_NUM'(1) << cur_id;
    assign is_mask  = IRQ_NUM'(1) << is_id;
    assign vec_calc = VEC_BASE + (CPU_WIDTH'(cand_id) << STRIDE_SH);

    assign wr       = en && we;
    assign set_bits = (irq_src & ~irq_d)
                    | ((wr && addr == REG_SWTRIG) ? wdata[IRQ_NUM-1:0] : '0);
    assign w1c_bits = (wr && addr == REG_PENDING) ? wdata[IRQ_NUM-1:0] : '0;

    // The latched request is withdrawn if its source is no longer pending, masked, or GIE is off.
    assign withdraw = (state == ST_REQ) && (!gie || ((pending & enable & cur_mask) == '0));
    assign take_ack = (state == ST_REQ) && irq_ack && !withdraw;
    assign take_eoi = (state == ST_SERVICE) && irq_eoi && is_valid;
    assign ack_clr  = take_ack ? cur_mask : '0;
    assign eoi_clr  = take_eoi ? is_mask : '0;

    // Sets are OR-ed in last so they beat a same-cycle W1C or ack clear.
    assign pending_next   = (pending & ~(w1c_bits | ack_clr)) | set_bits;
    assign inservice_next = (inservice & ~eoi_clr) | ack_clr;

`ifdef IRQ_NESTED_EN
    logic preempt;
    assign preempt = (state == ST_SERVICE) && cand_valid && is_valid && (cand_id < is_id);
`endif

    always_comb begin
        state_next = state;
        latch      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cand_valid) begin
                    state_next = ST_REQ;
                    latch      = 1'b1;
                end
            end
            ST_REQ: begin
                if (withdraw) begin
                    state_next = (inservice != '0) ? ST_SERVICE : ST_IDLE;
                end else if (irq_ack) begin
                    state_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (inservice_next == '0) begin
                    state_next = ST_IDLE;
                end
`ifdef IRQ_NESTED_EN
                if (preempt) begin
                    state_next = ST_REQ;
                    latch      = 1'b1;
                end
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            REG_CTRL:      rd_val = CPU_WIDTH'(gie);
            REG_ENABLE:    rd_val = CPU_WIDTH'(enable);
            REG_PENDING:   rd_val = CPU_WIDTH'(pending);
            REG_INSERVICE: rd_val = CPU_WIDTH'(inservice);
            REG_STATUS:    rd_val = CPU_WIDTH'({cur_id, 2'b00, state});
            default:       rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gie       <= 1'b0;
            enable    <= '0;
            pending   <= '0;
            inservice <= '0;
            irq_d     <= '0;
            cur_id    <= '0;
            irq_req   <= 1'b0;
            irq_vec   <= '0;
            rdata     <= '0;
        end else begin
            irq_d     <= irq_src;
            pending   <= pending_next;
            inservice <= inservice_next;
            irq_req   <= (state_next == ST_REQ);
            if (wr && addr == REG_CTRL) begin
                gie <= wdata[0];
            end
            if (wr && addr == REG_ENABLE) begin
                enable <= wdata[IRQ_NUM-1:0];
            end
            if (latch) begin
                cur_id  <= cand_id;
                irq_vec <= vec_calc;
            end
            if (en && !we) begin
                rdata <= rd_val;
            end
        end
    end

endmodule
